// File: rtl/arrival_pkg.sv
// -----------------------------------------------------------------------------
// arrival_pkg
// Shared definitions for the arrival sequencer: the FSM state enumeration and
// the matching localparam encodings used by the RTL (the localparams keep the
// encoding visible to legacy tools that do not handle enums well).
// No ports.
// -----------------------------------------------------------------------------
package arrival_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DOCKED   = 2'd2
    } arrival_state_e;

    localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] ST_COUNTING = 2'd1;
    localparam logic [STATE_W-1:0] ST_DOCKED   = 2'd2;

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// One-second prescaler. Counts clock cycles while enabled and raises tick
// (combinationally) in the cycle where the count reaches CLK_HZ-1; the
// prescaler then wraps to 0 on the following edge.
//
// Parameters:
//   CLK_HZ  clock cycles per tick
// Ports:
//   Clock   in   rising-edge clock
//   Reset   in   synchronous active-high reset, clears the prescaler
//   clear   in   synchronous clear, takes priority over enable
//   enable  in   advance the prescaler this cycle
//   tick    out  high in the cycle that completes a one-second period
// -----------------------------------------------------------------------------
module sec_tick_gen
    import arrival_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // A 1-cycle period would give a zero-width counter; keep at least 1 bit.
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = enable && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/arrival_sequencer.sv
// -----------------------------------------------------------------------------
// arrival_sequencer
// Arrival countdown sequencer: a request starts an ARRIVE_SECS-second countdown
// (IDLE -> COUNTING); when it expires the block docks (DOCKED), raising a
// one-cycle arrive_pulse and holding arrived until the interlock acks.
//
// Build option:
//   ARRIVAL_ABORT_EN  when defined, abort in COUNTING cancels the countdown
//                     (wins over a simultaneous final tick). When undefined
//                     the abort port is present but has no effect.
//
// Parameters:
//   CLK_HZ       clock cycles per one-second tick
//   ARRIVE_SECS  countdown length in seconds (1..1023)
//   COUNT_W      width of the count output
// Ports:
//   Clock         in   rising-edge clock
//   Reset         in   synchronous active-high reset
//   request       in   one-cycle arrival request pulse
//   abort         in   one-cycle countdown cancel pulse
//   ack           in   one-cycle pulse when the outer port opens
//   count         out  seconds remaining
//   busy          out  high while counting
//   arrived       out  high while docked
//   arrive_pulse  out  one-cycle strobe on entry to DOCKED
// -----------------------------------------------------------------------------
module arrival_sequencer
    import arrival_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int ARRIVE_SECS = 5,
    parameter int COUNT_W     = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               request,
    input  logic               abort,
    input  logic               ack,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               arrived,
    output logic               arrive_pulse
);

    localparam logic [COUNT_W-1:0] START_COUNT = COUNT_W'(ARRIVE_SECS);
    localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               pulse_q;
    logic               pulse_d;

    logic tick;
    logic tick_clear;
    logic tick_en;
    logic cancel;

    // Decrement that stops at zero so count can never wrap.
    function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

`ifdef ARRIVAL_ABORT_EN
    assign cancel = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign cancel       = 1'b0;
`endif

    // The prescaler only runs while counting; holding it cleared elsewhere
    // guarantees every countdown starts from a fresh second.
    assign tick_en    = (state_q == ST_COUNTING);
    assign tick_clear = (state_q != ST_COUNTING) || cancel;

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (tick_clear),
        .enable (tick_en),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (request) begin
                    state_d = ST_COUNTING;
                    count_d = START_COUNT;
                end
            end
            ST_COUNTING: begin
                // Cancel is checked first so it beats a completing tick.
                if (cancel) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (tick) begin
                    count_d = sat_dec(count_q);
                    if (count_q == ONE) begin
                        state_d = ST_DOCKED;
                        pulse_d = 1'b1;
                    end
                end
            end
            ST_DOCKED: begin
                // request arriving with ack is simply dropped.
                count_d = '0;
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign count        = count_q;
    assign busy         = (state_q == ST_COUNTING);
    assign arrived      = (state_q == ST_DOCKED);
    assign arrive_pulse = pulse_q;

endmodule

// File: tb/tb_arrival_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arrival_sequencer
// Directed bench for arrival_sequencer with CLK_HZ=4, ARRIVE_SECS=3.
// Cycle n is the interval after the n-th rising edge; inputs set in cycle n
// are sampled at the edge that starts cycle n+1.
// Honors ARRIVAL_ABORT_EN for the abort scenario.
// -----------------------------------------------------------------------------
module tb_arrival_sequencer;

    localparam int CLK_HZ      = 4;
    localparam int ARRIVE_SECS = 3;
    localparam int COUNT_W     = 10;

    logic               Clock;
    logic               Reset;
    logic               request;
    logic               abort;
    logic               ack;
    logic [COUNT_W-1:0] count;
    logic               busy;
    logic               arrived;
    logic               arrive_pulse;

    int cyc;
    int passed;
    int total;
    int fails;

    arrival_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .ARRIVE_SECS (ARRIVE_SECS),
        .COUNT_W     (COUNT_W)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .request      (request),
        .abort        (abort),
        .ack          (ack),
        .count        (count),
        .busy         (busy),
        .arrived      (arrived),
        .arrive_pulse (arrive_pulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic next();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) next();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input bit b, input bit a, input bit p);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".arrived"}, 32'(arrived), 32'(a));
        chk({tag, ".pulse"}, 32'(arrive_pulse), 32'(p));
    endtask

    initial begin
        cyc     = 0;
        passed  = 0;
        total   = 0;
        fails   = 0;
        Reset   = 1'b1;
        request = 1'b0;
        abort   = 1'b0;
        ack     = 1'b0;

        next();
        chk_all("reset", 0, 0, 0, 0);
        go_to(2);
        Reset = 1'b0;

        // Basic countdown
        go_to(10); request = 1'b1; next(); request = 1'b0;
        chk_all("start", 3, 1, 0, 0);
        go_to(14); request = 1'b1; next(); request = 1'b0;
        chk_all("sec1_rereq", 2, 1, 0, 0);
        go_to(16); ack = 1'b1; next(); ack = 1'b0;
        chk_all("ack_counting", 2, 1, 0, 0);
        go_to(19);
        chk_all("sec2", 1, 1, 0, 0);
        go_to(22);
        chk_all("pre_dock", 1, 1, 0, 0);
        next();
        chk_all("dock", 0, 0, 1, 1);
        next();
        chk_all("dock_hold", 0, 0, 1, 0);
        go_to(29);
        chk_all("dock_wait", 0, 0, 1, 0);
        go_to(30); ack = 1'b1; next(); ack = 1'b0;
        chk_all("ack_docked", 0, 0, 0, 0);
        request = 1'b1; next(); request = 1'b0;
        chk_all("restart", 3, 1, 0, 0);

        // Abort coinciding with the final tick (cycle 43)
        go_to(43);
        chk_all("pre_abort", 1, 1, 0, 0);
        abort = 1'b1; next(); abort = 1'b0;
`ifdef ARRIVAL_ABORT_EN
        chk_all("abort", 0, 0, 0, 0);
`else
        chk_all("abort_ignored", 0, 0, 1, 1);
`endif
        ack = 1'b1; next(); ack = 1'b0;
        chk_all("after_abort", 0, 0, 0, 0);
        go_to(46); ack = 1'b1; next(); ack = 1'b0;
        chk_all("ack_idle", 0, 0, 0, 0);

        // Prescaler starts fresh; then reset mid-countdown
        go_to(48); request = 1'b1; next(); request = 1'b0;
        chk_all("start2", 3, 1, 0, 0);
        go_to(52);
        chk_all("pre_tick2", 3, 1, 0, 0);
        next();
        chk_all("tick2", 2, 1, 0, 0);
        go_to(55); Reset = 1'b1; request = 1'b1; ack = 1'b1;
        next(); Reset = 1'b0; request = 1'b0; ack = 1'b0;
        chk_all("reset_mid", 0, 0, 0, 0);
        for (int i = 57; i <= 69; i++) begin
            next();
            chk("no_pulse_after_reset", 32'(arrive_pulse), 32'(0));
        end

        // Request together with ack while docked is dropped
        go_to(70); request = 1'b1; next(); request = 1'b0;
        chk_all("start3", 3, 1, 0, 0);
        go_to(83);
        chk_all("dock3", 0, 0, 1, 1);
        go_to(85); request = 1'b1; ack = 1'b1; next(); request = 1'b0; ack = 1'b0;
        chk_all("req_ack_docked", 0, 0, 0, 0);
        next();
        chk_all("req_dropped", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
